// File: rtl/rom_loader.sv
// Serial program loader for the Hack instruction ROM: takes a length-prefixed,
// checksummed byte stream and writes big-endian 16-bit words from address 0.
module rom_loader #(
  parameter int ADDR_WIDTH     = 15,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [15:0]           wr_data,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [16:0] CAP = 17'(1) << ADDR_WIDTH;

  typedef enum logic [3:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO,
    S_WRITE, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            byte_q, byte_d;
  logic [7:0]            sum_q, sum_d;
  logic [15:0]           left_q, left_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  rx_ready_q, rx_ready_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]           wr_data_q, wr_data_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic                  accept;
  logic [15:0]           len_w;

  // rx_ready_q always mirrors "current state accepts bytes", so it qualifies the handshake
  assign accept = rx_valid && rx_ready_q;
  assign len_w  = {byte_q, rx_data};

  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    sum_d     = sum_q;
    left_d    = left_q;
    addr_d    = addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    tmo_d     = '0;
    if (rx_ready_q && !accept) begin
      tmo_d = tmo_q + TW'(1);
    end

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_LEN_HI;
          addr_d  = '0;
          sum_d   = '0;
          tmo_d   = '0;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          byte_d  = rx_data;
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          left_d = len_w;
          if (len_w == 16'd0) begin
            state_d = S_CHECK;
          end else if ({1'b0, len_w} > CAP) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_DATA_HI;
          end
        end
      end
      S_DATA_HI: begin
        if (accept) begin
          byte_d  = rx_data;
          sum_d   = sum_q + rx_data;
          state_d = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (accept) begin
          sum_d     = sum_q + rx_data;
          wr_addr_d = addr_q;
          wr_data_d = {byte_q, rx_data};
          state_d   = S_WRITE;
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + ADDR_WIDTH'(1);
        left_d  = left_q - 16'd1;
        state_d = (left_q == 16'd1) ? S_CHECK : S_DATA_HI;
      end
      S_CHECK: begin
        if (accept) begin
          state_d = (rx_data == sum_q) ? S_DONE : S_ERROR;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A stalled sender aborts the load; only byte-waiting states can time out
    if (rx_ready_q && !accept && (tmo_q + TW'(1) == TW'(TIMEOUT_CYCLES))) begin
      state_d = S_ERROR;
    end

    rx_ready_d  = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                  (state_d == S_DATA_HI) || (state_d == S_DATA_LO) ||
                  (state_d == S_CHECK);
    busy_d      = !((state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ERROR));
    wr_en_d     = (state_d == S_WRITE);
    done_d      = (state_d == S_DONE);
    error_d     = (state_d == S_ERROR);
    cpu_reset_d = busy_d || error_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      byte_q      <= '0;
      sum_q       <= '0;
      left_q      <= '0;
      addr_q      <= '0;
      tmo_q       <= '0;
      rx_ready_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      cpu_reset_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_q      <= byte_d;
      sum_q       <= sum_d;
      left_q      <= left_d;
      addr_q      <= addr_d;
      tmo_q       <= tmo_d;
      rx_ready_q  <= rx_ready_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign rx_ready  = rx_ready_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign cpu_reset = cpu_reset_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: doc/rom_loader.md
# rom_loader

Serial program loader: the write side of the Hack instruction ROM. Consumes a byte stream from the UART receiver, assembles big-endian 16-bit instruction words, and writes them to consecutive ROM addresses starting at 0. It holds the CPU in reset for the whole load and releases it only after a correct checksum. It sits between the UART receiver and the ROM write port, which is added alongside the ROM's combinational read port.

## Interface
- ADDR_WIDTH, 15, ROM address width; capacity is 2^ADDR_WIDTH words.
- TIMEOUT_CYCLES, 1000000, maximum idle clk cycles between accepted bytes before the block aborts.
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- rx_data  in  8  byte from the UART receiver.
- rx_valid  in  1  rx_data is valid this cycle.
- rx_ready  out  1  loader can take a byte; a byte transfers when rx_valid && rx_ready.
- wr_en  out  1  one-cycle ROM write strobe.
- wr_addr  out  ADDR_WIDTH  ROM write address.
- wr_data  out  16  ROM write data.
- cpu_reset  out  1  holds the CPU in reset while a load is active or has failed.
- busy  out  1  load in progress.
- done  out  1  last load completed with a good checksum; held until the next start.
- error  out  1  last load failed; held until the next start.

## Operation
- Frame format: LEN_HI, LEN_LO, then N words (high byte first), then CHK.
  - N = {LEN_HI, LEN_LO}.
  - CHK = 8-bit sum mod 256 of all data bytes. Length bytes are excluded.
- States and transitions:
  - IDLE -> LEN_HI on start.
  - LEN_HI -> LEN_LO on a byte.
  - LEN_LO -> DATA_HI on a byte.
    - If N == 0: go to CHECK instead.
    - If N > 2^ADDR_WIDTH: go to ERROR instead.
  - DATA_HI -> DATA_LO on a byte.
  - DATA_LO -> WRITE on a byte.
  - WRITE lasts one cycle and issues wr_en.
    - Goes to DATA_HI if the word count is not exhausted, otherwise to CHECK.
  - CHECK -> DONE on a byte equal to the running sum; -> ERROR on a mismatch.
  - DONE or ERROR -> LEN_HI on start.
- rx_ready = 1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHECK.
- The address counter clears to 0 on start and increments after each WRITE.
  - wr_addr = counter value during WRITE.
  - Words are written to 0 .. N-1.
- The running sum clears on start and adds every DATA_HI and DATA_LO byte, wrapping mod 256.
- Timeout:
  - The counter clears on each accepted byte and on start.
  - It counts in every rx_ready state.
  - Reaching TIMEOUT_CYCLES -> ERROR.
- cpu_reset = 1 from the cycle after start through the end of the load.
  - Drops to 0 in the cycle DONE is entered.
  - Stays 1 in ERROR.
- start while busy is ignored.
- start together with rx_valid in IDLE: start wins. The byte is not consumed because rx_ready = 0 in IDLE.

## Timing
- Reset values:
  - state = IDLE.
  - rx_ready = wr_en = busy = done = error = cpu_reset = 0.
  - wr_addr = 0, wr_data = 0.
  - sum, word counter and timeout counter = 0.
  - cpu_reset = 0 so a preloaded ROM image runs.
- All outputs are registered; none depends combinationally on its inputs.
- busy = 1 and cpu_reset = 1 in the cycle after start. State is LEN_HI in that cycle.
- wr_en is asserted the cycle after the DATA_LO byte is accepted. It is high for exactly one cycle, with wr_addr and wr_data stable for that cycle.
- Throughput: at most one byte per cycle. Each word costs 3 cycles (DATA_HI, DATA_LO, WRITE).
- done or error rises the cycle after the CHK byte is accepted. busy falls in the same cycle.
- Last address: with N = 2^ADDR_WIDTH the final write is to address 2^ADDR_WIDTH - 1. The counter wrapping to 0 afterwards has no effect.
- reset mid-load: the next cycle is IDLE with all reset values. The partial image remains in the ROM. cpu_reset drops to 0.

## Test plan
- Good load: start, then bytes 00 02 00 02 EC 10 FE.
  - wr_en pulses twice: (addr 0, 0x0002), then (addr 1, 0xEC10).
  - done = 1, error = 0, cpu_reset = 0.
- Bad checksum: same frame with CHK = 0xFD.
  - Both writes still occur.
  - error = 1, done = 0, cpu_reset stays 1.
- Boundary lengths:
  - N = 0 (bytes 00 00 00): no wr_en, done = 1.
  - N = 0x8001: ERROR straight after LEN_LO, with no further bytes accepted.
- Timeout: start, send 00 01 AB, then idle for TIMEOUT_CYCLES cycles (small parameter in the bench).
  - error = 1, rx_ready = 0, no wr_en.
- Start while busy: start mid-frame.
  - Ignored; wr_addr and sum continue, and the frame completes with done = 1.
- Reset mid-load: reset asserted after the first WRITE.
  - All outputs return to reset values.
  - A following start plus a full good frame loads correctly from address 0.
